// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing and datapath strobes.
// Latency: 2 (j/jal), 3 (beq/jr), 4 (R/ori/lui/sw), 5 (lw) cycles plus one per mem_ready=0 cycle.
// Backpressure: FETCH and MEM hold while mem_ready=0; all strobes are combinational from state+inputs.
//
// Ports:
//   clk, reset              - single clock, asynchronous active-high reset
//   opcode, funct, zero     - IR[31:26], IR[5:0], ALU equality flag
//   mem_ready               - memory transaction completes this cycle
//   pc_we/pc_src, ir_we     - PC and IR update controls
//   mem_req/mem_we/iord     - memory request, write, address select (0 PC, 1 ALU)
//   rf_we/reg_dst/wd_sel    - register file write controls
//   alu_src/ext_op/alu_op   - ALU operand and operation selects
//   state, retired, illegal - FSM state code, retired-instruction count, illegal-decode pulse

module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        ir_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        rf_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic        alu_src,
  output logic [1:0]  ext_op,
  output logic [2:0]  alu_op,
  output logic [2:0]  state,
  output logic [31:0] retired,
  output logic        illegal
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t cur, nxt;
  logic   retire;

  // instruction decode
  logic is_r, i_addu, i_subu, i_jr, i_ori, i_lw, i_sw, i_beq, i_lui, i_j, i_jal, legal;

  always_comb begin
    is_r   = (opcode == 6'b000000);
    i_addu = is_r && (funct == 6'b100001);
    i_subu = is_r && (funct == 6'b100011);
    i_jr   = is_r && (funct == 6'b001000);
    i_ori  = (opcode == 6'b001101);
    i_lw   = (opcode == 6'b100011);
    i_sw   = (opcode == 6'b101011);
    i_beq  = (opcode == 6'b000100);
    i_lui  = (opcode == 6'b001111);
    i_j    = (opcode == 6'b000010);
    i_jal  = (opcode == 6'b000011);
    legal  = i_addu | i_subu | i_jr | i_ori | i_lw | i_sw | i_beq | i_lui | i_j | i_jal;
  end

  always_comb begin
    nxt     = cur;
    retire  = 1'b0;
    pc_we   = 1'b0;
    pc_src  = 2'd0;
    ir_we   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    iord    = 1'b0;
    rf_we   = 1'b0;
    reg_dst = 2'd0;
    wd_sel  = 2'd0;
    alu_src = 1'b0;
    ext_op  = 2'd0;
    alu_op  = 3'd0;
    illegal = 1'b0;

    case (cur)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          nxt   = DECODE;
        end
      end

      DECODE: begin
        if (i_j || i_jal) begin
          pc_we  = 1'b1;
          pc_src = 2'd2;
          retire = 1'b1;
          nxt    = FETCH;
          if (i_jal) begin
            // PC was already advanced in FETCH, so the link value is PC itself
            rf_we   = 1'b1;
            reg_dst = 2'd2;
            wd_sel  = 2'd2;
          end
        end else if (!legal) begin
          illegal = 1'b1;
          nxt     = FETCH;
        end else begin
          nxt = EXEC;
        end
      end

      EXEC: begin
        nxt = FETCH;
        if (i_addu) begin
          nxt = WB;
        end else if (i_subu) begin
          alu_op = 3'd1;
          nxt    = WB;
        end else if (i_ori) begin
          alu_op  = 3'd2;
          alu_src = 1'b1;
          nxt     = WB;
        end else if (i_lui) begin
          alu_op  = 3'd2;
          alu_src = 1'b1;
          ext_op  = 2'd2;
          nxt     = WB;
        end else if (i_lw || i_sw) begin
          alu_src = 1'b1;
          ext_op  = 2'd1;
          nxt     = MEM;
        end else if (i_beq) begin
          alu_op = 3'd1;
          ext_op = 2'd1;
          pc_src = 2'd1;
          pc_we  = zero;
          retire = 1'b1;
        end else if (i_jr) begin
          pc_we  = 1'b1;
          pc_src = 2'd3;
          retire = 1'b1;
        end
      end

      MEM: begin
        // address operands held so the ALU result stays valid across stalls
        mem_req = 1'b1;
        iord    = 1'b1;
        alu_src = 1'b1;
        ext_op  = 2'd1;
        mem_we  = i_sw;
        if (mem_ready) begin
          if (i_sw) begin
            retire = 1'b1;
            nxt    = FETCH;
          end else if (i_lw) begin
            nxt = WB;
          end else begin
            nxt = FETCH;
          end
        end
      end

      WB: begin
        rf_we   = 1'b1;
        reg_dst = is_r ? 2'd1 : 2'd0;
        wd_sel  = i_lw ? 2'd1 : 2'd0;
        retire  = 1'b1;
        nxt     = FETCH;
      end

      default: begin
        nxt = FETCH;
      end
    endcase

    // reset must silence write/request strobes immediately, not at the next edge
    if (reset) begin
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      rf_we   = 1'b0;
      illegal = 1'b0;
      retire  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur     <= FETCH;
      retired <= 32'd0;
    end else begin
      cur <= nxt;
      if (retire) retired <= retired + 32'd1;
    end
  end

  assign state = cur;

endmodule
